mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 26 ++
 rtl/mem_access_ctrl.sv | 149 ++++++++++++++
 rtl/mem_stage.sv | 91 +++++++++
 tb/tb_mem_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage types: handshake FSM states, word/register widths, MEM/WB layout.
// The default memory timeout is defined here so the pipeline top and the sub-module agree on it.
package mem_stage_pkg;

  localparam int WORD_W             = 32;
  localparam int REG_W              = 5;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  reg_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic     reg_write;
    logic     mem_to_reg;
    word_t    read_data;
    word_t    alu_out;
    reg_idx_t write_reg;
  } mem_wb_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// Data-memory handshake FSM (IDLE/ACCESS/DONE) with load buffer; stalls from request until ack, min 2 cycles.
// Optional ACCESS wait counter and sticky error under MEM_TIMEOUT_EN; state updates on the falling clock edge.
module mem_access_ctrl
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [WORD_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_ack,
  input  logic [WORD_W-1:0] i_rdata,
  output logic              o_req,
  output logic              o_we,
  output logic [WORD_W-1:0] o_addr,
  output logic [WORD_W-1:0] o_wdata,
  output logic              o_stall,
  output logic              o_done,
  output logic [WORD_W-1:0] o_load_data,
  output logic              o_err
);

  mem_state_t r_state;
  mem_state_t w_next;
  logic       r_req;
  logic       r_we;
  word_t      r_addr;
  word_t      r_wdata;
  word_t      r_load;
  logic       w_memop;
  logic       w_start;
  logic       w_timeout;

  assign w_memop = i_mem_read | i_mem_write;
  // Reset must silence the request at once even if EX/MEM still holds a memory op.
  assign w_start = w_memop & ~rst;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  assign w_timeout = (r_state == ST_ACCESS) & ~i_ack & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state != ST_ACCESS) begin
      r_cnt <= '0;
    end else if (!i_ack) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign o_err     = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_memop) w_next = ST_ACCESS;
      ST_ACCESS: if (i_ack || w_timeout) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req   = r_req;
    o_we    = r_we;
    o_addr  = r_addr;
    o_wdata = r_wdata;
    o_stall = 1'b0;
    o_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          o_req   = 1'b1;
          o_we    = i_mem_write;
          o_addr  = i_addr;
          o_wdata = i_wdata;
          o_stall = 1'b1;
        end
      end
      ST_ACCESS: o_stall = 1'b1;
      ST_DONE:   o_done  = 1'b1;
      default:   o_stall = 1'b0;
    endcase
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_load  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_memop) begin
            r_req   <= 1'b1;
            r_we    <= i_mem_write;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
          end
        end
        ST_ACCESS: begin
          if (i_ack) begin
            r_req  <= 1'b0;
            r_we   <= 1'b0;
            r_load <= i_rdata;
          end else if (w_timeout) begin
            r_req  <= 1'b0;
            r_we   <= 1'b0;
            r_load <= '0;
          end
        end
        default: r_req <= 1'b0;
      endcase
    end
  end

  assign o_load_data = r_load;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch resolve, data-memory access via mem_access_ctrl, MEM/WB register (falling edge).
// Non-memory ops take one cycle; memory ops stall upstream until ack. MEM_TIMEOUT_EN enables the access timeout.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_mem_Branch,
  input  logic              ex_mem_MemRead,
  input  logic              ex_mem_MemWrite,
  input  logic              ex_mem_RegWrite,
  input  logic              ex_mem_MemtoReg,
  input  logic              ex_mem_zero,
  input  logic [WORD_W-1:0] ex_mem_ALU_out,
  input  logic [WORD_W-1:0] ex_mem_read_reg_data_2,
  input  logic [WORD_W-1:0] ex_mem_adder2_result,
  input  logic [REG_W-1:0]  ex_mem_write_reg,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [WORD_W-1:0] dmem_addr,
  output logic [WORD_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [WORD_W-1:0] dmem_rdata,
  output logic              stall,
  output logic              PCSrc,
  output logic [WORD_W-1:0] branch_target,
  output logic              mem_wb_RegWrite,
  output logic              mem_wb_MemtoReg,
  output logic [WORD_W-1:0] mem_wb_read_data,
  output logic [WORD_W-1:0] mem_wb_ALU_out,
  output logic [REG_W-1:0]  mem_wb_write_reg,
  output logic              mem_err
);

  mem_wb_t r_mem_wb;
  logic    w_stall;
  logic    w_done;
  word_t   w_load;

  assign PCSrc         = ex_mem_Branch & ex_mem_zero;
  assign branch_target = ex_mem_adder2_result;

  mem_access_ctrl #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_access (
    .clk        (clk),
    .rst        (rst),
    .i_mem_read (ex_mem_MemRead),
    .i_mem_write(ex_mem_MemWrite),
    .i_addr     (ex_mem_ALU_out),
    .i_wdata    (ex_mem_read_reg_data_2),
    .i_ack      (dmem_ack),
    .i_rdata    (dmem_rdata),
    .o_req      (dmem_req),
    .o_we       (dmem_we),
    .o_addr     (dmem_addr),
    .o_wdata    (dmem_wdata),
    .o_stall    (w_stall),
    .o_done     (w_done),
    .o_load_data(w_load),
    .o_err      (mem_err)
  );

  assign stall = w_stall;

  // A stalled cycle retires nothing: only the write enable is squashed, the rest holds.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_mem_wb <= '0;
    end else if (w_stall) begin
      r_mem_wb.reg_write <= 1'b0;
    end else begin
      r_mem_wb.reg_write  <= ex_mem_RegWrite;
      r_mem_wb.mem_to_reg <= ex_mem_MemtoReg;
      r_mem_wb.alu_out    <= ex_mem_ALU_out;
      r_mem_wb.write_reg  <= ex_mem_write_reg;
      if (w_done && ex_mem_MemRead && !ex_mem_MemWrite) begin
        r_mem_wb.read_data <= w_load;
      end
    end
  end

  assign mem_wb_RegWrite  = r_mem_wb.reg_write;
  assign mem_wb_MemtoReg  = r_mem_wb.mem_to_reg;
  assign mem_wb_read_data = r_mem_wb.read_data;
  assign mem_wb_ALU_out   = r_mem_wb.alu_out;
  assign mem_wb_write_reg = r_mem_wb.write_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases then random instruction mix against a transaction model.
`timescale 1ns/1ps
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        ex_mem_Branch, ex_mem_MemRead, ex_mem_MemWrite;
  logic        ex_mem_RegWrite, ex_mem_MemtoReg, ex_mem_zero;
  logic [31:0] ex_mem_ALU_out, ex_mem_read_reg_data_2, ex_mem_adder2_result;
  logic [4:0]  ex_mem_write_reg;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall, PCSrc;
  logic [31:0] branch_target;
  logic        mem_wb_RegWrite, mem_wb_MemtoReg;
  logic [31:0] mem_wb_read_data, mem_wb_ALU_out;
  logic [4:0]  mem_wb_write_reg;
  logic        mem_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit        rw;
    bit        m2r;
    bit [31:0] rd;
    bit [31:0] alu;
    bit [4:0]  wr;
  } wb_t;

  wb_t exp_wb;
  bit  exp_err;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ex_mem_Branch(ex_mem_Branch), .ex_mem_MemRead(ex_mem_MemRead),
    .ex_mem_MemWrite(ex_mem_MemWrite), .ex_mem_RegWrite(ex_mem_RegWrite),
    .ex_mem_MemtoReg(ex_mem_MemtoReg), .ex_mem_zero(ex_mem_zero),
    .ex_mem_ALU_out(ex_mem_ALU_out), .ex_mem_read_reg_data_2(ex_mem_read_reg_data_2),
    .ex_mem_adder2_result(ex_mem_adder2_result), .ex_mem_write_reg(ex_mem_write_reg),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .PCSrc(PCSrc), .branch_target(branch_target),
    .mem_wb_RegWrite(mem_wb_RegWrite), .mem_wb_MemtoReg(mem_wb_MemtoReg),
    .mem_wb_read_data(mem_wb_read_data), .mem_wb_ALU_out(mem_wb_ALU_out),
    .mem_wb_write_reg(mem_wb_write_reg), .mem_err(mem_err)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_wb(input string tag);
    chk({tag, ".RegWrite"},  {31'd0, mem_wb_RegWrite}, {31'd0, exp_wb.rw});
    chk({tag, ".MemtoReg"},  {31'd0, mem_wb_MemtoReg}, {31'd0, exp_wb.m2r});
    chk({tag, ".read_data"}, mem_wb_read_data, exp_wb.rd);
    chk({tag, ".ALU_out"},   mem_wb_ALU_out, exp_wb.alu);
    chk({tag, ".write_reg"}, {27'd0, mem_wb_write_reg}, {27'd0, exp_wb.wr});
    chk({tag, ".mem_err"},   {31'd0, mem_err}, {31'd0, exp_err});
  endtask

  // Runs one instruction from its first MEM cycle to retirement. Called #1 after a falling edge.
  // lat = ACCESS cycle (1-based) in which the memory acks; noack leaves the access to time out.
  task automatic run_instr(input string tag, input bit br, input bit rd, input bit wr,
                           input bit rw, input bit m2r, input bit z,
                           input bit [31:0] alu, input bit [31:0] d2, input bit [31:0] tgt,
                           input bit [4:0] wreg, input int lat, input bit [31:0] rdata,
                           input bit noack);
    bit memop;
    memop = rd | wr;
    ex_mem_Branch = br;  ex_mem_MemRead = rd;   ex_mem_MemWrite = wr;
    ex_mem_RegWrite = rw; ex_mem_MemtoReg = m2r; ex_mem_zero = z;
    ex_mem_ALU_out = alu; ex_mem_read_reg_data_2 = d2; ex_mem_adder2_result = tgt;
    ex_mem_write_reg = wreg;
    // Spurious acks outside ACCESS (request cycle, DONE) must be ignored.
    dmem_ack = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom();
    if (memop) begin
      for (int k = 0; k <= lat; k++) begin
        if (k > 0) begin
          dmem_ack   = (k == lat) && !noack;
          dmem_rdata = (k == lat) ? rdata : $urandom();
        end
        @(posedge clk);
        chk({tag, ".stall"},  {31'd0, stall}, 32'd1);
        chk({tag, ".req"},    {31'd0, dmem_req}, 32'd1);
        chk({tag, ".we"},     {31'd0, dmem_we}, {31'd0, wr});
        chk({tag, ".addr"},   dmem_addr, alu);
        chk({tag, ".wdata"},  dmem_wdata, d2);
        chk({tag, ".PCSrc"},  {31'd0, PCSrc}, {31'd0, br & z});
        @(negedge clk); #1;
        exp_wb.rw = 1'b0;
        if (k == lat && noack) exp_err = 1'b1;
        chk_wb({tag, ".stalled"});
      end
      dmem_ack   = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom();
      @(posedge clk);
      chk({tag, ".done_stall"}, {31'd0, stall}, 32'd0);
      chk({tag, ".done_req"},   {31'd0, dmem_req}, 32'd0);
    end else begin
      @(posedge clk);
      chk({tag, ".stall"}, {31'd0, stall}, 32'd0);
      chk({tag, ".req"},   {31'd0, dmem_req}, 32'd0);
    end
    chk({tag, ".PCSrc"},  {31'd0, PCSrc}, {31'd0, br & z});
    chk({tag, ".target"}, branch_target, tgt);
    @(negedge clk); #1;
    dmem_ack = 1'b0;
    exp_wb.rw  = rw;
    exp_wb.m2r = m2r;
    exp_wb.alu = alu;
    exp_wb.wr  = wreg;
    if (rd && !wr) exp_wb.rd = noack ? 32'd0 : rdata;
    chk_wb({tag, ".retire"});
  endtask

  task automatic drive_nop();
    ex_mem_Branch = 0; ex_mem_MemRead = 0; ex_mem_MemWrite = 0;
    ex_mem_RegWrite = 0; ex_mem_MemtoReg = 0; ex_mem_zero = 0;
    ex_mem_ALU_out = 0; ex_mem_read_reg_data_2 = 0; ex_mem_adder2_result = 0;
    ex_mem_write_reg = 0;
  endtask

  initial begin
    int kind;
    rst = 1'b1;
    drive_nop();
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    exp_wb = '{default: 0};
    exp_err = 1'b0;

    #3;
    chk("reset.stall", {31'd0, stall}, 32'd0);
    chk("reset.req",   {31'd0, dmem_req}, 32'd0);
    chk("reset.we",    {31'd0, dmem_we}, 32'd0);
    chk("reset.addr",  dmem_addr, 32'd0);
    chk("reset.wdata", dmem_wdata, 32'd0);
    chk_wb("reset");
    @(negedge clk); #1;
    rst = 1'b0;

    run_instr("alu",      0, 0, 0, 1, 0, 0, 32'h10,  32'h0, 32'h0, 5'd5, 0, 32'h0, 0);
    run_instr("load",     0, 1, 0, 1, 1, 0, 32'h100, 32'h0, 32'h0, 5'd7, 3, 32'hDEADBEEF, 0);
    run_instr("nop",      0, 0, 0, 0, 0, 0, 32'h0,   32'h0, 32'h0, 5'd0, 0, 32'h0, 0);
    run_instr("store",    0, 0, 1, 0, 0, 0, 32'h20,  32'h12345678, 32'h0, 5'd3, 1, 32'h0BADF00D, 0);
    run_instr("br_taken", 1, 0, 0, 0, 0, 1, 32'h0,   32'h0, 32'h40, 5'd0, 0, 32'h0, 0);
    run_instr("br_not",   1, 0, 0, 0, 0, 0, 32'h0,   32'h0, 32'h40, 5'd0, 0, 32'h0, 0);
    run_instr("rdwr",     0, 1, 1, 1, 1, 0, 32'h33,  32'hA5A5A5A5, 32'h0, 5'd9, 2, 32'h11112222, 0);
    run_instr("load_b",   0, 1, 0, 1, 1, 0, 32'h0,   32'h0, 32'h0, 5'd1, 1, 32'h87654321, 0);

    // Reset in the middle of an access, then a late ack.
    ex_mem_MemRead = 1'b1; ex_mem_RegWrite = 1'b1; ex_mem_ALU_out = 32'h200;
    @(negedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    exp_wb = '{default: 0};
    exp_err = 1'b0;
    chk("rst_mid.req",   {31'd0, dmem_req}, 32'd0);
    chk("rst_mid.stall", {31'd0, stall}, 32'd0);
    chk_wb("rst_mid");
    drive_nop();
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    @(posedge clk);
    chk("late_ack.req",   {31'd0, dmem_req}, 32'd0);
    chk("late_ack.stall", {31'd0, stall}, 32'd0);
    @(negedge clk); #1;
    dmem_ack = 1'b0;
    chk_wb("late_ack");
    @(negedge clk); #1;
    chk_wb("late_ack2");

`ifdef MEM_TIMEOUT_EN
    run_instr("timeout",  0, 1, 0, 1, 1, 0, 32'h300, 32'h0, 32'h0, 5'd4, 4, 32'h0, 1);
    run_instr("post_to",  0, 0, 0, 1, 0, 0, 32'h44,  32'h0, 32'h0, 5'd6, 0, 32'h0, 0);
    rst = 1'b1;
    #1;
    exp_wb = '{default: 0};
    exp_err = 1'b0;
    chk_wb("to_reset");
    @(negedge clk); #1;
    rst = 1'b0;
`endif

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 3));
      run_instr("rand",
                1'($urandom_range(0, 1)),
                kind == 1 || kind == 3,
                kind == 2 || kind == 3,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom(), $urandom(), $urandom(), 5'($urandom_range(0, 31)),
                int'($urandom_range(1, 4)), $urandom(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
